// File: rtl/lift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lift_pkg
// Description : Shared types and constants for the lift call scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package lift_pkg;
  localparam int NFLOORS = 8;
  localparam int FLOOR_W = 3;

  typedef logic [FLOOR_W-1:0] floor_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PICK  = 2'd1,
    OFFER = 2'd2,
    SENT  = 2'd3
  } sched_state_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;
endpackage
`default_nettype wire

// File: rtl/call_request_scheduler_btn_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : btn_sync_edge
// Description : Multi-stage synchronizer for raw asynchronous buttons followed
//               by a rising-edge detector producing one-cycle pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_sync_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_async,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;

  // Shift raw buttons through the synchronizer and remember the last stable value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
      r_prev <= '0;
    end else begin
      r_sync[0] <= btn_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // A held button produces a single pulse, so it cannot re-arm a served call
  assign rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/call_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : call_request_scheduler
// Description : Latches cab/hall calls, clears them on door-open service and
//               issues one target floor at a time in SCAN order over a
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module call_request_scheduler #(
  parameter int NFLOORS     = 8,
  parameter int FLOOR_W     = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NFLOORS-1:0] cab_btn,
  input  logic [NFLOORS-1:0] hall_up_btn,
  input  logic [NFLOORS-1:0] hall_dn_btn,
  input  logic [FLOOR_W-1:0] current_floor,
  input  logic [1:0]         door,
  input  logic               emergency_stop,
  output logic [FLOOR_W-1:0] req_floor,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [NFLOORS-1:0] pending
);
  import lift_pkg::*;

  // No hall-up call exists at the top floor, no hall-down call at the bottom
  localparam logic [NFLOORS-1:0] c_UP_VALID = ~({{(NFLOORS-1){1'b0}}, 1'b1} << (NFLOORS-1));
  localparam logic [NFLOORS-1:0] c_DN_VALID = ~{{(NFLOORS-1){1'b0}}, 1'b1};

  logic [NFLOORS-1:0] w_cab_rise;
  logic [NFLOORS-1:0] w_up_rise;
  logic [NFLOORS-1:0] w_dn_rise;
  logic [NFLOORS-1:0] r_cab_q;
  logic [NFLOORS-1:0] r_up_q;
  logic [NFLOORS-1:0] r_dn_q;
  logic [NFLOORS-1:0] w_clr_mask;
  logic [NFLOORS-1:0] w_pending;
  logic [NFLOORS-1:0] w_between;
  logic               w_preempt;
  logic [FLOOR_W:0]   w_sel;
  sched_state_t       r_state;
  dir_t               r_dir;
  logic               r_estop_d;

  btn_sync_edge #(.WIDTH(NFLOORS), .SYNC_STAGES(SYNC_STAGES)) u_cab_sync (
    .clk(clk), .reset(reset), .btn_async(cab_btn), .rise(w_cab_rise)
  );
  btn_sync_edge #(.WIDTH(NFLOORS), .SYNC_STAGES(SYNC_STAGES)) u_up_sync (
    .clk(clk), .reset(reset), .btn_async(hall_up_btn), .rise(w_up_rise)
  );
  btn_sync_edge #(.WIDTH(NFLOORS), .SYNC_STAGES(SYNC_STAGES)) u_dn_sync (
    .clk(clk), .reset(reset), .btn_async(hall_dn_btn), .rise(w_dn_rise)
  );

  // SCAN target choice; result is {new_dir, target}. Falls back to the current
  // floor only when nothing is pending above or below it.
  function automatic logic [FLOOR_W:0] f_select(
    input logic [NFLOORS-1:0] p,
    input logic [FLOOR_W-1:0] cur,
    input dir_t               dir
  );
    logic               above_hit;
    logic               below_hit;
    logic [FLOOR_W-1:0] above_f;
    logic [FLOOR_W-1:0] below_f;
    logic [FLOOR_W-1:0] tgt;
    logic               new_dir;
    above_hit = 1'b0;
    below_hit = 1'b0;
    above_f   = cur;
    below_f   = cur;
    // Descending scan so the last hit is the lowest floor above
    for (int i = NFLOORS-1; i >= 0; i--) begin
      if (p[i] && (i > int'(cur))) begin
        above_hit = 1'b1;
        above_f   = FLOOR_W'(i);
      end
    end
    // Ascending scan so the last hit is the highest floor below
    for (int i = 0; i < NFLOORS; i++) begin
      if (p[i] && (i < int'(cur))) begin
        below_hit = 1'b1;
        below_f   = FLOOR_W'(i);
      end
    end
    tgt     = cur;
    new_dir = dir;
    if (dir == DIR_UP) begin
      if (above_hit) begin
        tgt = above_f;
      end else if (below_hit) begin
        tgt     = below_f;
        new_dir = DIR_DN;
      end
    end else begin
      if (below_hit) begin
        tgt = below_f;
      end else if (above_hit) begin
        tgt     = above_f;
        new_dir = DIR_UP;
      end
    end
    return {new_dir, tgt};
  endfunction

  assign w_clr_mask = (door == 2'd1) ? ({{(NFLOORS-1){1'b0}}, 1'b1} << current_floor) : '0;
  assign w_pending  = r_cab_q | r_up_q | r_dn_q;
  assign pending    = w_pending;
  assign w_sel      = f_select(w_pending, current_floor, r_dir);

  // Floors strictly between the cab and the committed target, in travel direction
  always_comb begin
    w_between = '0;
    for (int i = 0; i < NFLOORS; i++) begin
      if (r_dir == DIR_UP) begin
        w_between[i] = (i > int'(current_floor)) && (i < int'(req_floor));
      end else begin
        w_between[i] = (i < int'(current_floor)) && (i > int'(req_floor));
      end
    end
  end

  assign w_preempt = |(w_pending & w_between);

  // Latch call edges; service clear at the open-door floor wins over a new edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cab_q <= '0;
      r_up_q  <= '0;
      r_dn_q  <= '0;
    end else begin
      r_cab_q <= (r_cab_q | w_cab_rise) & ~w_clr_mask;
      r_up_q  <= (r_up_q | (w_up_rise & c_UP_VALID)) & ~w_clr_mask;
      r_dn_q  <= (r_dn_q | (w_dn_rise & c_DN_VALID)) & ~w_clr_mask;
    end
  end

  // Scheduler FSM with registered request outputs; req_floor doubles as target
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_dir     <= DIR_UP;
      r_estop_d <= 1'b0;
      req_floor <= '0;
      req_valid <= 1'b0;
    end else begin
      r_estop_d <= emergency_stop;
      if (emergency_stop) begin
        req_valid <= 1'b0;
        // A request already accepted on this edge still counts as sent
        if (r_state == OFFER) begin
          r_state <= req_ready ? SENT : PICK;
        end
      end else if (r_estop_d) begin
        // Re-evaluate the target right after an emergency release
        req_valid <= 1'b0;
        r_state   <= PICK;
      end else begin
        case (r_state)
          IDLE: begin
            if (|w_pending) begin
              r_state <= PICK;
            end
          end
          PICK: begin
            if (|w_pending) begin
              req_floor <= w_sel[FLOOR_W-1:0];
              r_dir     <= dir_t'(w_sel[FLOOR_W]);
              req_valid <= 1'b1;
              r_state   <= OFFER;
            end else begin
              r_state <= IDLE;
            end
          end
          OFFER: begin
            if (req_ready) begin
              req_valid <= 1'b0;
              r_state   <= SENT;
            end
          end
          SENT: begin
            if (!w_pending[req_floor] || w_preempt) begin
              r_state <= PICK;
            end
          end
          default: begin
            req_valid <= 1'b0;
            r_state   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_call_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_call_request_scheduler
// Description : Self-checking bench for call_request_scheduler: directed
//               scenarios plus randomized SCAN sequences against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_call_request_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cab_btn;
  logic [7:0] hall_up_btn;
  logic [7:0] hall_dn_btn;
  logic [2:0] current_floor;
  logic [1:0] door;
  logic       emergency_stop;
  logic [2:0] req_floor;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] pending;

  int checks   = 0;
  int failures = 0;

  call_request_scheduler #(.NFLOORS(8), .FLOOR_W(3), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .cab_btn(cab_btn), .hall_up_btn(hall_up_btn),
    .hall_dn_btn(hall_dn_btn), .current_floor(current_floor), .door(door),
    .emergency_stop(emergency_stop), .req_floor(req_floor), .req_valid(req_valid),
    .req_ready(req_ready), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bounded wait for an offer; ok=0 when the budget runs out
  task automatic wait_valid(input int budget, output bit ok);
    ok = req_valid;
    for (int i = 0; i < budget && !ok; i++) begin
      tick(1);
      ok = req_valid;
    end
  endtask

  task automatic accept();
    req_ready = 1'b1;
    tick(1);
    req_ready = 1'b0;
  endtask

  task automatic serve(input int f);
    current_floor = 3'(f);
    door = 2'd1;
    tick(2);
    door = 2'd0;
  endtask

  // SCAN rule written directly from the floor-choice rules
  task automatic model_pick(input logic [7:0] p, input int cur, inout int dir, output int tgt);
    int above;
    int below;
    above = -1;
    below = -1;
    for (int f = 7; f > cur; f--) if (p[f]) above = f;
    for (int f = 0; f < cur; f++) if (p[f]) below = f;
    tgt = cur;
    if (dir == 0) begin
      if (above >= 0) tgt = above;
      else if (below >= 0) begin tgt = below; dir = 1; end
    end else begin
      if (below >= 0) tgt = below;
      else if (above >= 0) begin tgt = above; dir = 0; end
    end
  endtask

  task automatic expect_offer(input string name, input int exp);
    bit ok;
    wait_valid(12, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: req_valid timeout, got 0 required 1", name);
    end else begin
      checks++;
      if (req_floor !== 3'(exp)) begin
        failures++;
        $display("FAIL %s: req_floor got %0d required %0d", name, req_floor, exp);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cab_btn = 8'hFF; hall_up_btn = 8'hFF; hall_dn_btn = 8'hFF;
    tick(3);
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b required 0", req_valid); end
    checks++; if (req_floor !== 3'd0) begin failures++; $display("FAIL reset_floor: got %0d required 0", req_floor); end
    checks++; if (pending !== 8'h00) begin failures++; $display("FAIL reset_pending: got %h required 00", pending); end
    cab_btn = 8'h00; hall_up_btn = 8'h00; hall_dn_btn = 8'h00;
    tick(1);
    reset = 1'b1;
    tick(4);
    checks++; if (pending !== 8'h00) begin failures++; $display("FAIL post_reset_pending: got %h required 00", pending); end
  endtask

  task automatic test_single_call();
    current_floor = 3'd0;
    cab_btn[5] = 1'b1;
    tick(2);
    cab_btn[5] = 1'b0;
    checks++; if (pending !== 8'h00) begin failures++; $display("FAIL single_early: got %h required 00", pending); end
    tick(1);
    checks++; if (pending !== 8'h20) begin failures++; $display("FAIL single_latency: got %h required 20", pending); end
    tick(1);
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL single_pick: got %b required 0", req_valid); end
    tick(1);
    checks++; if (req_valid !== 1'b1 || req_floor !== 3'd5) begin failures++; $display("FAIL single_offer: got v=%b f=%0d required v=1 f=5", req_valid, req_floor); end
    tick(3);
    checks++; if (req_valid !== 1'b1 || req_floor !== 3'd5) begin failures++; $display("FAIL single_hold: got v=%b f=%0d required v=1 f=5", req_valid, req_floor); end
    accept();
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL single_drop: got %b required 0", req_valid); end
    serve(5);
    tick(3);
    checks++; if (pending !== 8'h00 || req_valid !== 1'b0) begin failures++; $display("FAIL single_served: got p=%h v=%b required p=00 v=0", pending, req_valid); end
  endtask

  task automatic test_scan_order();
    current_floor = 3'd3;
    cab_btn = 8'h52;
    tick(1);
    cab_btn = 8'h00;
    tick(2);
    checks++; if (pending !== 8'h52) begin failures++; $display("FAIL scan_latch: got %h required 52", pending); end
    expect_offer("scan_first", 4);  accept(); serve(4);
    expect_offer("scan_second", 6); accept(); serve(6);
    expect_offer("scan_turn", 1);   accept(); serve(1);
    tick(3);
    checks++; if (pending !== 8'h00) begin failures++; $display("FAIL scan_drain: got %h required 00", pending); end
  endtask

  task automatic test_preempt();
    current_floor = 3'd2;
    cab_btn[6] = 1'b1;
    tick(1);
    cab_btn[6] = 1'b0;
    expect_offer("preempt_initial", 6);
    accept();
    hall_up_btn[4] = 1'b1;
    tick(1);
    hall_up_btn[4] = 1'b0;
    tick(2);
    checks++; if (pending !== 8'h50 || req_valid !== 1'b0) begin failures++; $display("FAIL preempt_latch: got p=%h v=%b required p=50 v=0", pending, req_valid); end
    expect_offer("preempt_target", 4); accept(); serve(4);
    expect_offer("preempt_resume", 6); accept(); serve(6);
  endtask

  task automatic test_clear_vs_set();
    current_floor = 3'd2;
    door = 2'd1;
    cab_btn[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++; if (pending[2] !== 1'b0) begin failures++; $display("FAIL clear_beats_set: cycle %0d got %b required 0", i, pending[2]); end
    end
    door = 2'd0;
    tick(5);
    checks++; if (pending !== 8'h00 || req_valid !== 1'b0) begin failures++; $display("FAIL held_no_rearm: got p=%h v=%b required p=00 v=0", pending, req_valid); end
    cab_btn[2] = 1'b0;
    tick(2);
  endtask

  task automatic test_emergency();
    bit ok;
    current_floor = 3'd6;
    cab_btn = 8'h84;
    tick(1);
    cab_btn = 8'h00;
    expect_offer("estop_before", 7);
    emergency_stop = 1'b1;
    tick(1);
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL estop_drop: got %b required 0", req_valid); end
    cab_btn[0] = 1'b1;
    tick(1);
    cab_btn[0] = 1'b0;
    tick(3);
    checks++; if (pending !== 8'h85 || req_valid !== 1'b0) begin failures++; $display("FAIL estop_latch: got p=%h v=%b required p=85 v=0", pending, req_valid); end
    emergency_stop = 1'b0;
    wait_valid(2, ok);
    checks++;
    if (!ok || req_floor !== 3'd7) begin
      failures++;
      $display("FAIL estop_release: got v=%b f=%0d required v=1 f=7", req_valid, req_floor);
    end
    accept(); serve(7);
    expect_offer("estop_down1", 2); accept(); serve(2);
    expect_offer("estop_down2", 0); accept(); serve(0);
  endtask

  task automatic test_async_reset_offer();
    current_floor = 3'd0;
    cab_btn[3] = 1'b1;
    tick(1);
    cab_btn[3] = 1'b0;
    expect_offer("areset_setup", 3);
    #2;
    reset = 1'b0;
    req_ready = 1'b1;
    #1;
    checks++; if (req_valid !== 1'b0 || pending !== 8'h00) begin failures++; $display("FAIL areset_immediate: got v=%b p=%h required v=0 p=00", req_valid, pending); end
    tick(1);
    reset = 1'b1;
    req_ready = 1'b0;
    tick(4);
    checks++; if (req_valid !== 1'b0 || pending !== 8'h00) begin failures++; $display("FAIL areset_after: got v=%b p=%h required v=0 p=00", req_valid, pending); end
  endtask

  // Random batches of calls drained in SCAN order; the model restarts from
  // reset state (direction UP) left by the preceding asynchronous reset test
  task automatic test_random_scan();
    logic [7:0] mp;
    logic [7:0] nb;
    logic [7:0] c;
    logic [7:0] u;
    logic [7:0] d;
    int mdir;
    int mcur;
    int tgt;
    int iter;
    bit ok;
    mdir = 0;
    for (int b = 0; b < 10; b++) begin
      mcur = $urandom_range(0, 7);
      current_floor = 3'(mcur);
      tick(1);
      c = 8'($urandom & $urandom) | (8'h01 << $urandom_range(0, 7));
      u = 8'($urandom & $urandom);
      d = 8'($urandom & $urandom);
      cab_btn = c; hall_up_btn = u; hall_dn_btn = d;
      tick(1);
      cab_btn = 8'h00; hall_up_btn = 8'h00; hall_dn_btn = 8'h00;
      tick(2);
      mp = c | (u & 8'h7F) | (d & 8'hFE);
      checks++; if (pending !== mp) begin failures++; $display("FAIL rnd_latch b%0d: got %h required %h", b, pending, mp); end
      iter = 0;
      while (mp != 8'h00 && iter < 20) begin
        model_pick(mp, mcur, mdir, tgt);
        wait_valid(12, ok);
        checks++;
        if (!ok || req_floor !== 3'(tgt)) begin
          failures++;
          $display("FAIL rnd_target b%0d i%0d: got v=%b f=%0d required v=1 f=%0d", b, iter, req_valid, req_floor, tgt);
        end
        if (iter == 0 && ($urandom_range(0, 1) == 1)) begin
          nb = 8'($urandom);
          cab_btn = nb;
          tick(1);
          cab_btn = 8'h00;
          tick(3);
          mp = mp | nb;
          checks++;
          if (req_valid !== 1'b1 || req_floor !== 3'(tgt)) begin
            failures++;
            $display("FAIL rnd_stable b%0d: got v=%b f=%0d required v=1 f=%0d", b, req_valid, req_floor, tgt);
          end
        end
        current_floor = 3'(tgt);
        door = 2'd1;
        req_ready = 1'b1;
        tick(1);
        req_ready = 1'b0;
        tick(1);
        door = 2'd0;
        mp[tgt] = 1'b0;
        mcur = tgt;
        checks++; if (pending !== mp) begin failures++; $display("FAIL rnd_pending b%0d i%0d: got %h required %h", b, iter, pending, mp); end
        iter++;
      end
      tick(4);
      checks++; if (req_valid !== 1'b0 || pending !== 8'h00) begin failures++; $display("FAIL rnd_idle b%0d: got v=%b p=%h required v=0 p=00", b, req_valid, pending); end
    end
  endtask

  initial begin
    reset = 1'b0;
    cab_btn = 8'h00; hall_up_btn = 8'h00; hall_dn_btn = 8'h00;
    current_floor = 3'd0; door = 2'd0; emergency_stop = 1'b0; req_ready = 1'b0;
    test_reset();
    test_single_call();
    test_scan_order();
    test_preempt();
    test_clear_vs_set();
    test_emergency();
    test_async_reset_offer();
    test_random_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
